// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin denominations and the change-dispenser state
// encoding (also decoded by led_feedback).
package vm_pkg;

  localparam logic [7:0] COIN_1 = 8'd1;
  localparam logic [7:0] COIN_2 = 8'd2;
  localparam logic [7:0] COIN_5 = 8'd5;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StEmit,
    StGap,
    StDone,
    StShort
  } disp_state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Request, refill and payout signals between the change dispenser and its neighbours.
interface change_dispenser_if #(
  parameter int unsigned TUBE_W = 4
);

  logic              start;
  logic [7:0]        amount;
  logic              coin_pulse;
  logic [7:0]        coin_value;
  logic              restock;
  logic              busy;
  logic              dispense_pulse;
  logic [7:0]        dispense_value;
  logic [7:0]        remaining;
  logic              done;
  logic              short_change;
  logic [TUBE_W-1:0] tube5;
  logic [TUBE_W-1:0] tube2;
  logic [TUBE_W-1:0] tube1;

  modport master (
    output start, amount, coin_pulse, coin_value, restock,
    input  busy, dispense_pulse, dispense_value, remaining, done, short_change,
    input  tube5, tube2, tube1
  );

  modport slave (
    input  start, amount, coin_pulse, coin_value, restock,
    output busy, dispense_pulse, dispense_value, remaining, done, short_change,
    output tube5, tube2, tube1
  );

endinterface

// File: rtl/gap_timer.sv
// Down-counter pacing dispense pulses: load starts a CYCLES-long wait, expired while at zero.
module gap_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
  // Loading CYCLES-1 makes expired assert in the CYCLES-th enabled cycle.
  localparam logic [W-1:0] LoadVal = (CYCLES > 0) ? W'(CYCLES - 1) : '0;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LoadVal;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy 5/2/1 change payout from three refillable coin tubes, one paced pulse per coin.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 25000000,
  parameter int unsigned TUBE_MAX   = 15,
  parameter int unsigned TUBE_INIT  = 4,
  parameter int unsigned TUBE_W     = 4
) (
  input logic               clk,
  input logic               rst,
  change_dispenser_if.slave bus
);

  localparam logic [TUBE_W-1:0] TubeFull = TUBE_W'(TUBE_MAX);
  localparam logic [TUBE_W-1:0] TubeInit = TUBE_W'(TUBE_INIT);

  disp_state_e       state_q, state_d;
  logic [7:0]        remaining_q, sel_q, pick;
  logic              pick_ok, gap_expired;
  logic [TUBE_W-1:0] tube5_q, tube2_q, tube1_q;
  logic              busy_q, pulse_q, done_q, short_q;
  logic              busy_d, pulse_d, done_d, short_d;
  logic [7:0]        value_q, value_d;
  logic              idle, emit, fill;

  assign idle = (state_q == StIdle);
  assign emit = (state_q == StEmit);
  assign fill = bus.restock && idle;

  // A refill and a dispense hitting the same tube cancel, even when the tube is full.
  function automatic logic [TUBE_W-1:0] tube_next(input logic [TUBE_W-1:0] cur,
                                                  input logic refill, input logic take,
                                                  input logic restock_hit);
    if (restock_hit) return TubeFull;
    if (refill && !take) return (cur < TubeFull) ? cur + TUBE_W'(1) : cur;
    if (take && !refill) return cur - TUBE_W'(1);
    return cur;
  endfunction

  always_comb begin
    pick    = 8'd0;
    pick_ok = 1'b0;
    if ((tube5_q != '0) && (remaining_q >= COIN_5)) begin
      pick    = COIN_5;
      pick_ok = 1'b1;
    end else if ((tube2_q != '0) && (remaining_q >= COIN_2)) begin
      pick    = COIN_2;
      pick_ok = 1'b1;
    end else if ((tube1_q != '0) && (remaining_q >= COIN_1)) begin
      pick    = COIN_1;
      pick_ok = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StSelect;
      StSelect: begin
        if (remaining_q == 8'd0) state_d = StDone;
        else if (pick_ok)        state_d = StEmit;
        else                     state_d = StShort;
      end
      StEmit:   state_d = (GAP_CYCLES == 0) ? StSelect : StGap;
      StGap:    if (gap_expired) state_d = StSelect;
      StDone:   state_d = StIdle;
      StShort:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered, so each one appears one edge after the state that decodes it.
  always_comb begin
    busy_d  = (state_q == StSelect) || (state_q == StEmit) || (state_q == StGap);
    pulse_d = emit;
    value_d = emit ? sel_q : 8'd0;
    done_d  = (state_q == StDone);
    short_d = (state_q == StShort);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      value_q <= 8'd0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
      value_q <= value_d;
      done_q  <= done_d;
      short_q <= short_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q <= 8'd0;
      sel_q       <= 8'd0;
    end else begin
      if (idle && bus.start) begin
        remaining_q <= bus.amount;
      end else if (emit) begin
        remaining_q <= remaining_q - sel_q;
      end
      if (state_q == StSelect) sel_q <= pick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tube5_q <= TubeInit;
      tube2_q <= TubeInit;
      tube1_q <= TubeInit;
    end else begin
      tube5_q <= tube_next(tube5_q, bus.coin_pulse && (bus.coin_value == COIN_5),
                           emit && (sel_q == COIN_5), fill);
      tube2_q <= tube_next(tube2_q, bus.coin_pulse && (bus.coin_value == COIN_2),
                           emit && (sel_q == COIN_2), fill);
      tube1_q <= tube_next(tube1_q, bus.coin_pulse && (bus.coin_value == COIN_1),
                           emit && (sel_q == COIN_1), fill);
    end
  end

  gap_timer #(
    .CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (emit),
    .en     (state_q == StGap),
    .expired(gap_expired)
  );

  assign bus.busy           = busy_q;
  assign bus.dispense_pulse = pulse_q;
  assign bus.dispense_value = value_q;
  assign bus.remaining      = remaining_q;
  assign bus.done           = done_q;
  assign bus.short_change   = short_q;
  assign bus.tube5          = tube5_q;
  assign bus.tube2          = tube2_q;
  assign bus.tube1          = tube1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: per-cycle vector table plus hand-written payout,
// refill-during-emit and reset-during-gap sequences.
module tb_change_dispenser;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   chk_cnt;

  change_dispenser_if #(.TUBE_W(4)) bus ();

  change_dispenser #(
    .GAP_CYCLES(4),
    .TUBE_MAX  (15),
    .TUBE_INIT (4),
    .TUBE_W    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int start, amount, coin, cval, restock, reps;
    int busy, pulse, val, rem, done, shrt, t5, t2, t1;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d required %0d", nm, got, exp);
  endtask

  task automatic chk_tubes(input string nm, input int t5, input int t2, input int t1);
    chk({nm, "_t5"}, 32'(bus.tube5), t5);
    chk({nm, "_t2"}, 32'(bus.tube2), t2);
    chk({nm, "_t1"}, 32'(bus.tube1), t1);
  endtask

  // Coins are pulsed 2 cycles after start and then every GAP+2 = 6 cycles; done/short
  // lands one gap after the last coin (or at offset 2 when nothing is paid).
  task automatic pay(input string nm, input int amt, input int n, input int c0, input int c1,
                     input int c2, input int c3, input bit exp_short, input int poke_off);
    int coins[4];
    int rem;
    int ci;
    int end_off;
    bit exp_pulse;
    int exp_val;
    coins = '{c0, c1, c2, c3};
    bus.start  = 1'b1;
    bus.amount = 8'(amt);
    tick();
    bus.start  = 1'b0;
    bus.amount = 8'd0;
    chk({nm, "_latch"}, 32'(bus.remaining), amt);
    chk({nm, "_busy0"}, 32'(bus.busy), 0);
    rem     = amt;
    ci      = 0;
    end_off = 2 + 6 * n;
    for (int o = 1; o <= end_off; o++) begin
      if (o == poke_off) begin
        bus.start  = 1'b1;
        bus.amount = 8'd200;
      end
      tick();
      bus.start  = 1'b0;
      bus.amount = 8'd0;
      exp_pulse  = (o >= 2) && (((o - 2) % 6) == 0) && (ci < n);
      exp_val    = 0;
      if (exp_pulse) begin
        exp_val = coins[ci];
        rem     = rem - coins[ci];
        ci++;
      end
      chk($sformatf("%s_o%0d_pulse", nm, o), 32'(bus.dispense_pulse), 32'(exp_pulse));
      chk($sformatf("%s_o%0d_value", nm, o), 32'(bus.dispense_value), exp_val);
      chk($sformatf("%s_o%0d_rem", nm, o), 32'(bus.remaining), rem);
      if (o == end_off) begin
        chk($sformatf("%s_o%0d_done", nm, o), 32'(bus.done), 32'(!exp_short));
        chk($sformatf("%s_o%0d_short", nm, o), 32'(bus.short_change), 32'(exp_short));
        chk($sformatf("%s_o%0d_busy", nm, o), 32'(bus.busy), 0);
      end else begin
        chk($sformatf("%s_o%0d_busy", nm, o), 32'(bus.busy), 1);
        chk($sformatf("%s_o%0d_end", nm, o), 32'(bus.done | bus.short_change), 0);
      end
    end
    tick();
    chk({nm, "_after_end"}, 32'(bus.done | bus.short_change | bus.busy), 0);
    chk({nm, "_after_rem"}, 32'(bus.remaining), rem);
  endtask

  initial begin
    bit quiet;
    pass_cnt        = 0;
    chk_cnt         = 0;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.amount      = 8'd0;
    bus.coin_pulse  = 1'b0;
    bus.coin_value  = 8'd0;
    bus.restock     = 1'b0;

    //          S  A  C  V  R  n  B  P  Val Rem D  Sh t5  t2  t1
    tbl.push_back('{1, 8, 0, 0, 0, 1, 0, 0, 0, 8, 0, 0, 4, 4, 4});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 0, 0, 8, 0, 0, 4, 4, 4});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 1, 5, 3, 0, 0, 3, 4, 4});
    tbl.push_back('{0, 0, 0, 0, 0, 5, 1, 0, 0, 3, 0, 0, 3, 4, 4});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 1, 2, 1, 0, 0, 3, 3, 4});
    tbl.push_back('{0, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0, 0, 3, 3, 4});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 3, 3, 3});
    tbl.push_back('{0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 3, 3, 3});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 3, 3, 3});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 3, 3});
    tbl.push_back('{0, 0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 4, 3, 3});
    tbl.push_back('{0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 4, 4, 3});
    tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4, 4, 4});
    tbl.push_back('{0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 4, 4, 4});
    tbl.push_back('{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 4, 4});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 15, 15, 15});
    tbl.push_back('{0, 0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 15, 15, 15});
    tbl.push_back('{0, 0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 15, 15, 15});

    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_pulse", 32'(bus.dispense_pulse), 0);
    chk("rst_value", 32'(bus.dispense_value), 0);
    chk("rst_rem", 32'(bus.remaining), 0);
    chk("rst_done_short", 32'(bus.done | bus.short_change), 0);
    chk_tubes("rst", 4, 4, 4);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      bus.start      = tbl[i].start[0];
      bus.amount     = tbl[i].amount[7:0];
      bus.coin_pulse = tbl[i].coin[0];
      bus.coin_value = tbl[i].cval[7:0];
      bus.restock    = tbl[i].restock[0];
      for (int r = 0; r < tbl[i].reps; r++) begin
        tick();
        chk($sformatf("v%0d_%0d_busy", i, r), 32'(bus.busy), tbl[i].busy);
        chk($sformatf("v%0d_%0d_pulse", i, r), 32'(bus.dispense_pulse), tbl[i].pulse);
        chk($sformatf("v%0d_%0d_value", i, r), 32'(bus.dispense_value), tbl[i].val);
        chk($sformatf("v%0d_%0d_rem", i, r), 32'(bus.remaining), tbl[i].rem);
        chk($sformatf("v%0d_%0d_done", i, r), 32'(bus.done), tbl[i].done);
        chk($sformatf("v%0d_%0d_short", i, r), 32'(bus.short_change), tbl[i].shrt);
        chk_tubes($sformatf("v%0d_%0d", i, r), tbl[i].t5, tbl[i].t2, tbl[i].t1);
      end
    end
    bus.start      = 1'b0;
    bus.amount     = 8'd0;
    bus.coin_pulse = 1'b0;
    bus.coin_value = 8'd0;
    bus.restock    = 1'b0;
    tick();

    // Tubes 15/15/15, amount 10: refill during the second EMIT of a 5 nets to zero,
    // restock while busy is ignored.
    bus.start  = 1'b1;
    bus.amount = 8'd10;
    tick();
    bus.start  = 1'b0;
    bus.amount = 8'd0;
    tick();
    tick();
    chk("emit1_value", 32'(bus.dispense_value), 5);
    chk_tubes("emit1", 14, 15, 15);
    bus.restock = 1'b1;
    tick();
    bus.restock = 1'b0;
    chk_tubes("restock_busy", 14, 15, 15);
    for (int k = 0; k < 4; k++) tick();
    bus.coin_pulse = 1'b1;
    bus.coin_value = 8'd5;
    tick();
    bus.coin_pulse = 1'b0;
    bus.coin_value = 8'd0;
    chk("emit2_pulse", 32'(bus.dispense_pulse), 1);
    chk("emit2_value", 32'(bus.dispense_value), 5);
    chk("emit2_rem", 32'(bus.remaining), 0);
    chk_tubes("emit2_refill", 14, 15, 15);
    for (int k = 0; k < 5; k++) tick();
    tick();
    chk("emit_seq_done", 32'(bus.done), 1);
    chk("emit_seq_busy", 32'(bus.busy), 0);
    tick();

    // Reset in the middle of a gap aborts immediately.
    bus.start  = 1'b1;
    bus.amount = 8'd8;
    tick();
    bus.start  = 1'b0;
    bus.amount = 8'd0;
    tick();
    tick();
    chk("pre_rst_pulse", 32'(bus.dispense_pulse), 1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_pulse", 32'(bus.dispense_pulse | bus.done | bus.short_change), 0);
    chk("midrst_rem", 32'(bus.remaining), 0);
    chk_tubes("midrst", 4, 4, 4);
    tick();
    rst   = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.dispense_pulse || bus.busy) quiet = 1'b0;
    end
    chk("post_rst_quiet", 32'(quiet), 1);

    pay("p20", 20, 4, 5, 5, 5, 5, 1'b0, 0);
    chk_tubes("p20", 0, 4, 4);
    pay("p7", 7, 4, 2, 2, 2, 1, 1'b0, 4);
    chk_tubes("p7", 0, 1, 3);
    pay("p4", 4, 3, 2, 1, 1, 0, 1'b0, 0);
    chk_tubes("p4", 0, 0, 1);
    pay("p3", 3, 1, 1, 0, 0, 0, 1'b1, 0);
    chk_tubes("p3", 0, 0, 0);
    tick();
    chk("short_hold_rem", 32'(bus.remaining), 2);
    chk("short_hold_busy", 32'(bus.busy), 0);
    pay("p0", 0, 0, 0, 0, 0, 0, 1'b0, 1);
    chk_tubes("p0", 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
